// File: rtl/gpr_writeback.sv
// GPR file write side: owns the 32x32 array, commits up to three writes per cycle,
// forwards same-cycle writes to decode and interlocks decode on outstanding loads.
module gpr_writeback #(
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned NREG     = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      wb_u_flag,
  input  logic [4:0]                wb_u_rt,
  input  logic [31:0]               wb_u_data,
  input  logic                      wb_l_flag,
  input  logic [4:0]                wb_l_rt,
  input  logic [31:0]               wb_l_data,
  input  logic                      ld_issue_valid,
  input  logic [4:0]                ld_issue_rt,
  input  logic [31:0]               ld_data,
  input  logic                      dec_valid,
  input  logic [14:0]               dec_src_u,
  input  logic [14:0]               dec_src_l,
  output logic [NREG-1:0][31:0]     gpr_rd,
  output logic                      interlock,
  output logic [NREG-1:0]           pending,
  output logic [31:0]               stall_cnt
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  typedef struct packed {
    logic          v;
    logic [RW-1:0] rt;
  } ld_tag_t;

  ld_tag_t                tag_q [LOAD_LAT];
  logic [NREG-1:0][DW-1:0] array_q;
  logic [NREG-1:0]        pending_q, pending_d;
  logic [DW-1:0]          stall_cnt_q, stall_cnt_d;
  logic                   ld_ret;
  logic [RW-1:0]          ret_rt;

  assign ld_ret = tag_q[LOAD_LAT-1].v;
  assign ret_rt = tag_q[LOAD_LAT-1].rt;

  // Load tag pipe: one stage per cycle of memory latency, never stalls
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag_q[0] <= '0;
    end else begin
      tag_q[0] <= '{v: ld_issue_valid, rt: ld_issue_rt};
    end
  end

  for (genvar s = 1; s < LOAD_LAT; s++) begin : g_tag_pipe
    always_ff @(posedge clk) begin
      if (!rstn) begin
        tag_q[s] <= '0;
      end else begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // Forwarded read view; later assignments win, giving L > U > M
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      gpr_rd[r] = array_q[r];
      if (ld_ret && ret_rt == RW'(r))       gpr_rd[r] = ld_data;
      if (wb_u_flag && wb_u_rt == RW'(r))   gpr_rd[r] = wb_u_data;
      if (wb_l_flag && wb_l_rt == RW'(r))   gpr_rd[r] = wb_l_data;
    end
  end

  // The array simply captures the forwarded view every cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      array_q <= '0;
    end else begin
      array_q <= gpr_rd;
    end
  end

  // Scoreboard: issue beats return, return/ALU write clears
  always_comb begin
    pending_d = pending_q;
    for (int r = 0; r < NREG; r++) begin
      if ((wb_u_flag && wb_u_rt == RW'(r)) || (wb_l_flag && wb_l_rt == RW'(r)))
        pending_d[r] = 1'b0;
      if (ld_ret && ret_rt == RW'(r))
        pending_d[r] = 1'b0;
      if (ld_issue_valid && ld_issue_rt == RW'(r))
        pending_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

  // A source stalls only if pending and not being returned this very cycle
  function automatic logic src_blocked(input logic [RW-1:0] src);
    return pending_q[src] & ~(ld_ret & (ret_rt == src));
  endfunction

  always_comb begin
    interlock = 1'b0;
    if (dec_valid) begin
      interlock = src_blocked(dec_src_u[14:10]) | src_blocked(dec_src_u[9:5]) |
                  src_blocked(dec_src_u[4:0])   | src_blocked(dec_src_l[14:10]) |
                  src_blocked(dec_src_l[9:5])   | src_blocked(dec_src_l[4:0]);
    end
  end

  // Saturating stall counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (interlock && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed bench for gpr_writeback: writes, collisions, load interlock, scoreboard, reset, saturation.
module tb_gpr_writeback;

  logic              clk = 1'b0;
  logic              rstn;
  logic              wb_u_flag, wb_l_flag, ld_issue_valid, dec_valid;
  logic [4:0]        wb_u_rt, wb_l_rt, ld_issue_rt;
  logic [31:0]       wb_u_data, wb_l_data, ld_data;
  logic [14:0]       dec_src_u, dec_src_l;
  logic [31:0][31:0] gpr_rd;
  logic              interlock;
  logic [31:0]       pending;
  logic [31:0]       stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  gpr_writeback #(.LOAD_LAT(2), .NREG(32)) dut (
    .clk(clk), .rstn(rstn),
    .wb_u_flag(wb_u_flag), .wb_u_rt(wb_u_rt), .wb_u_data(wb_u_data),
    .wb_l_flag(wb_l_flag), .wb_l_rt(wb_l_rt), .wb_l_data(wb_l_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rt(ld_issue_rt), .ld_data(ld_data),
    .dec_valid(dec_valid), .dec_src_u(dec_src_u), .dec_src_l(dec_src_l),
    .gpr_rd(gpr_rd), .interlock(interlock), .pending(pending), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are changed right after the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wb_u_flag = 0; wb_u_rt = 0; wb_u_data = 0;
    wb_l_flag = 0; wb_l_rt = 0; wb_l_data = 0;
    ld_issue_valid = 0; ld_issue_rt = 0; ld_data = 0;
    dec_valid = 0; dec_src_u = 0; dec_src_l = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    tick();
    tick();
    rstn = 1'b1;
    #1;
    n_vec++; if (gpr_rd !== '0) begin n_err++; $display("FAIL reset_gpr: got %h expected 0", gpr_rd); end
    n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL reset_pending: got %h expected 0", pending); end
    n_vec++; if (stall_cnt !== 32'h0) begin n_err++; $display("FAIL reset_stall: got %h expected 0", stall_cnt); end
    n_vec++; if (interlock !== 1'b0) begin n_err++; $display("FAIL reset_interlock: got %b expected 0", interlock); end
  endtask

  task automatic test_single_write();
    wb_u_flag = 1; wb_u_rt = 5'd3; wb_u_data = 32'h1234_5678;
    #1;
    n_vec++; if (gpr_rd[3] !== 32'h1234_5678) begin n_err++; $display("FAIL wr_fwd: got %h expected 12345678", gpr_rd[3]); end
    tick();
    idle();
    #1;
    n_vec++; if (gpr_rd[3] !== 32'h1234_5678) begin n_err++; $display("FAIL wr_array: got %h expected 12345678", gpr_rd[3]); end
    n_vec++; if (gpr_rd[4] !== 32'h0) begin n_err++; $display("FAIL wr_other4: got %h expected 0", gpr_rd[4]); end
    n_vec++; if (gpr_rd[2] !== 32'h0) begin n_err++; $display("FAIL wr_other2: got %h expected 0", gpr_rd[2]); end
  endtask

  task automatic test_collision();
    // Three-way collision on r5, and U vs M on r6
    ld_issue_valid = 1; ld_issue_rt = 5'd5;
    tick();
    ld_issue_rt = 5'd6;
    tick();
    idle();
    ld_data = 32'hCCCC;
    wb_u_flag = 1; wb_u_rt = 5'd5; wb_u_data = 32'hAAAA;
    wb_l_flag = 1; wb_l_rt = 5'd5; wb_l_data = 32'hBBBB;
    #1;
    n_vec++; if (gpr_rd[5] !== 32'hBBBB) begin n_err++; $display("FAIL coll3_fwd: got %h expected 0000bbbb", gpr_rd[5]); end
    tick();
    idle();
    ld_data = 32'hDDDD;
    wb_u_flag = 1; wb_u_rt = 5'd6; wb_u_data = 32'hEEEE;
    #1;
    n_vec++; if (gpr_rd[5] !== 32'hBBBB) begin n_err++; $display("FAIL coll3_array: got %h expected 0000bbbb", gpr_rd[5]); end
    n_vec++; if (gpr_rd[6] !== 32'hEEEE) begin n_err++; $display("FAIL coll_um_fwd: got %h expected 0000eeee", gpr_rd[6]); end
    tick();
    idle();
    #1;
    n_vec++; if (gpr_rd[6] !== 32'hEEEE) begin n_err++; $display("FAIL coll_um_array: got %h expected 0000eeee", gpr_rd[6]); end
    n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL coll_pending: got %h expected 0", pending); end
  endtask

  task automatic test_load_interlock();
    ld_issue_valid = 1; ld_issue_rt = 5'd7;
    tick();
    idle();
    dec_valid = 1; dec_src_u = {5'd7, 5'd0, 5'd0};
    #1;
    n_vec++; if (pending[7] !== 1'b1) begin n_err++; $display("FAIL ld_pending_set: got %b expected 1", pending[7]); end
    n_vec++; if (interlock !== 1'b1) begin n_err++; $display("FAIL ld_interlock: got %b expected 1", interlock); end
    tick();
    ld_data = 32'h55;
    #1;
    n_vec++; if (interlock !== 1'b0) begin n_err++; $display("FAIL ld_ret_nostall: got %b expected 0", interlock); end
    n_vec++; if (gpr_rd[7] !== 32'h55) begin n_err++; $display("FAIL ld_ret_fwd: got %h expected 00000055", gpr_rd[7]); end
    tick();
    idle();
    #1;
    n_vec++; if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL ld_stall_cnt: got %0d expected 1", stall_cnt); end
    n_vec++; if (pending[7] !== 1'b0) begin n_err++; $display("FAIL ld_pending_clr: got %b expected 0", pending[7]); end
    n_vec++; if (gpr_rd[7] !== 32'h55) begin n_err++; $display("FAIL ld_array: got %h expected 00000055", gpr_rd[7]); end
  endtask

  task automatic test_back_to_back();
    ld_issue_valid = 1; ld_issue_rt = 5'd9;
    tick();
    idle();
    tick();
    ld_issue_valid = 1; ld_issue_rt = 5'd9; ld_data = 32'h111;
    #1;
    n_vec++; if (gpr_rd[9] !== 32'h111) begin n_err++; $display("FAIL b2b_first_fwd: got %h expected 00000111", gpr_rd[9]); end
    tick();
    idle();
    dec_valid = 1; dec_src_l = {5'd0, 5'd0, 5'd9};
    #1;
    n_vec++; if (pending[9] !== 1'b1) begin n_err++; $display("FAIL b2b_pending_held: got %b expected 1", pending[9]); end
    n_vec++; if (interlock !== 1'b1) begin n_err++; $display("FAIL b2b_interlock_rs_l: got %b expected 1", interlock); end
    tick();
    ld_data = 32'h222;
    #1;
    n_vec++; if (interlock !== 1'b0) begin n_err++; $display("FAIL b2b_ret_nostall: got %b expected 0", interlock); end
    tick();
    idle();
    #1;
    n_vec++; if (pending[9] !== 1'b0) begin n_err++; $display("FAIL b2b_pending_clr: got %b expected 0", pending[9]); end
    n_vec++; if (gpr_rd[9] !== 32'h222) begin n_err++; $display("FAIL b2b_array: got %h expected 00000222", gpr_rd[9]); end
    n_vec++; if (stall_cnt !== 32'd2) begin n_err++; $display("FAIL b2b_stall_cnt: got %0d expected 2", stall_cnt); end
  endtask

  task automatic test_alu_supersede();
    ld_issue_valid = 1; ld_issue_rt = 5'd4;
    tick();
    idle();
    wb_u_flag = 1; wb_u_rt = 5'd4; wb_u_data = 32'h99;
    #1;
    n_vec++; if (pending[4] !== 1'b1) begin n_err++; $display("FAIL sup_pending_set: got %b expected 1", pending[4]); end
    n_vec++; if (gpr_rd[4] !== 32'h99) begin n_err++; $display("FAIL sup_u_fwd: got %h expected 00000099", gpr_rd[4]); end
    tick();
    idle();
    ld_data = 32'h44;
    dec_valid = 1; dec_src_u = {5'd0, 5'd0, 5'd4};
    #1;
    n_vec++; if (pending[4] !== 1'b0) begin n_err++; $display("FAIL sup_pending_clr: got %b expected 0", pending[4]); end
    n_vec++; if (interlock !== 1'b0) begin n_err++; $display("FAIL sup_interlock: got %b expected 0", interlock); end
    n_vec++; if (gpr_rd[4] !== 32'h44) begin n_err++; $display("FAIL sup_ld_fwd: got %h expected 00000044", gpr_rd[4]); end
    tick();
    idle();
    #1;
    n_vec++; if (gpr_rd[4] !== 32'h44) begin n_err++; $display("FAIL sup_ld_array: got %h expected 00000044", gpr_rd[4]); end
    n_vec++; if (stall_cnt !== 32'd2) begin n_err++; $display("FAIL sup_stall_cnt: got %0d expected 2", stall_cnt); end
  endtask

  task automatic test_reset_inflight();
    ld_issue_valid = 1; ld_issue_rt = 5'd2;
    tick();
    idle();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    ld_data = 32'h77;
    #1;
    n_vec++; if (gpr_rd[2] !== 32'h0) begin n_err++; $display("FAIL rst_drop_fwd: got %h expected 0", gpr_rd[2]); end
    n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL rst_pending: got %h expected 0", pending); end
    n_vec++; if (gpr_rd[3] !== 32'h0) begin n_err++; $display("FAIL rst_array3: got %h expected 0", gpr_rd[3]); end
    tick();
    idle();
    #1;
    n_vec++; if (gpr_rd[2] !== 32'h0) begin n_err++; $display("FAIL rst_drop_array: got %h expected 0", gpr_rd[2]); end
  endtask

  task automatic test_saturation();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    tick();
    release dut.stall_cnt_q;
    #1;
    n_vec++; if (stall_cnt !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sat_preload: got %h expected fffffffe", stall_cnt); end
    // Alternate loads to r10/r11 so one sourced register is always pending and not returning
    ld_issue_valid = 1; ld_issue_rt = 5'd10;
    tick();
    ld_issue_rt = 5'd11;
    dec_valid = 1; dec_src_u = {5'd10, 5'd11, 5'd0};
    #1;
    n_vec++; if (interlock !== 1'b1) begin n_err++; $display("FAIL sat_interlock: got %b expected 1", interlock); end
    tick();
    ld_issue_rt = 5'd10;
    #1;
    n_vec++; if (stall_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_reach: got %h expected ffffffff", stall_cnt); end
    n_vec++; if (interlock !== 1'b1) begin n_err++; $display("FAIL sat_interlock2: got %b expected 1", interlock); end
    tick();
    idle();
    #1;
    n_vec++; if (stall_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_hold: got %h expected ffffffff", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_collision();
    test_load_interlock();
    test_back_to_back();
    test_alu_supersede();
    test_reset_inflight();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1);
  end

endmodule
